hilo_muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer that owns the HI/LO special registers.
- Those registers feed the lo/hi inputs of the writeback select stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage.
- Runs a 32-iteration shift-add multiply or restoring divide, with a final sign-fix cycle.
- Raises a stall to the pipeline while an MFHI/MFLO read or a new HI/LO op would collide with a busy unit.

---
 rtl/hilo_muldiv_seq_if.sv | 25 ++
 rtl/hilo_muldiv_seq.sv | 135 +++++++++++++
 tb/tb_hilo_muldiv_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_seq_if.sv
// Execute-stage <-> HI/LO multiply/divide sequencer port bundle.
interface hilo_muldiv_seq_if #(
  parameter int unsigned DATA_BITS = 32
);
  logic                 start;
  logic [2:0]           op;
  logic [DATA_BITS-1:0] a;
  logic [DATA_BITS-1:0] b;
  logic                 read_req;
  logic [DATA_BITS-1:0] lo;
  logic [DATA_BITS-1:0] hi;
  logic                 busy;
  logic                 done;
  logic                 stall;

  modport master (
    output start, op, a, b, read_req,
    input  lo, hi, busy, done, stall
  );

  modport slave (
    input  start, op, a, b, read_req,
    output lo, hi, busy, done, stall
  );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// Iterative shift-add multiply / restoring divide owning the HI/LO registers.
// One iteration per cycle for DATA_BITS cycles, then one sign-fix cycle.
module hilo_muldiv_seq #(
  parameter int unsigned DATA_BITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  hilo_muldiv_seq_if.slave   bus
);

  localparam int unsigned W     = DATA_BITS;
  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

  localparam logic [2:0] OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]     hi_q, lo_q;
  logic             busy_q, done_q;
  logic [W-1:0]     ma, mb;
  logic [2*W-1:0]   acc;
  logic [W:0]       rem;
  logic [CNT_W-1:0] cnt;
  logic             is_div, neg_q, neg_r, div_zero;

  logic             accept_c, accept_md_c, op_signed_c;
  logic [W-1:0]     a_mag_c, b_mag_c;
  logic [W:0]       mul_sum_c;
  logic [W+1:0]     rem_sh_c, rem_diff_c;
  logic             q_bit_c;
  logic [2*W-1:0]   prod_fix_c;
  logic [W-1:0]     quo_fix_c, rem_fix_c;

  assign accept_c    = bus.start && !busy_q && (bus.op <= OP_MTLO);
  assign accept_md_c = accept_c && (bus.op <= OP_DIVU);
  assign op_signed_c = !bus.op[0];

  assign a_mag_c = (op_signed_c && bus.a[W-1]) ? W'(-bus.a) : bus.a;
  assign b_mag_c = (op_signed_c && bus.b[W-1]) ? W'(-bus.b) : bus.b;

  // Multiply step: add multiplicand into the upper half, shift the whole product right.
  assign mul_sum_c = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? ma : {W{1'b0}})};

  // Divide step: shift the next dividend bit into the remainder and trial-subtract.
  assign rem_sh_c   = {rem, acc[W-1]};
  assign rem_diff_c = rem_sh_c - {2'b00, mb};
  assign q_bit_c    = rem_sh_c[W+1] | ~rem_diff_c[W+1];

  assign prod_fix_c = neg_q ? (2*W)'(-acc) : acc;
  assign rem_fix_c  = neg_r ? W'(-rem[W-1:0]) : rem[W-1:0];
  // Divide by zero leaves |a| in the remainder, so the remainder sign fix restores a.
  assign quo_fix_c  = div_zero ? {W{1'b1}} : (neg_q ? W'(-acc[W-1:0]) : acc[W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_md_c) state_nxt = ITER;
      ITER:    if (cnt == CNT_W'(W - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ma       <= '0;
      mb       <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= (state == FIX);
      case (state)
        IDLE: begin
          if (accept_c && bus.op == OP_MTHI) hi_q <= bus.a;
          if (accept_c && bus.op == OP_MTLO) lo_q <= bus.a;
          if (accept_md_c) begin
            ma       <= a_mag_c;
            mb       <= b_mag_c;
            is_div   <= bus.op[1];
            neg_q    <= op_signed_c && (bus.a[W-1] ^ bus.b[W-1]);
            neg_r    <= op_signed_c && bus.a[W-1];
            div_zero <= bus.op[1] && (bus.b == '0);
            cnt      <= '0;
            rem      <= '0;
            acc      <= {{W{1'b0}}, (bus.op[1] ? a_mag_c : b_mag_c)};
          end
        end
        ITER: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div) begin
            rem          <= q_bit_c ? rem_diff_c[W:0] : rem_sh_c[W:0];
            acc[W-1:0]   <= {acc[W-2:0], q_bit_c};
          end else begin
            acc <= {mul_sum_c, acc[W-1:1]};
          end
        end
        FIX: begin
          hi_q <= is_div ? rem_fix_c : prod_fix_c[2*W-1:W];
          lo_q <= is_div ? quo_fix_c : prod_fix_c[W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q & (bus.read_req | bus.start);

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed bench for hilo_muldiv_seq: mul/div results, latency, stall and reset abort.
module tb_hilo_muldiv_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [31:0] hi_m, lo_m;

  hilo_muldiv_seq_if #(.DATA_BITS(32)) bus ();

  hilo_muldiv_seq #(.DATA_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a mul/div in the current cycle and check latency, hold and result.
  task automatic run_md(input string tag, input logic [2:0] op_v, input logic [31:0] a_v,
                        input logic [31:0] b_v, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int bad;
    bus.start = 1'b1; bus.op = op_v; bus.a = a_v; bus.b = b_v;
    tick();
    bus.start = 1'b0;
    bad = 0;
    for (int c = 1; c <= 33; c++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.hi !== hi_m || bus.lo !== lo_m) bad++;
      tick();
    end
    chk({tag, "_window"}, 64'(bad), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_busy_off"}, 64'(bus.busy), 64'd0);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    hi_m = exp_hi; lo_m = exp_lo;
    tick();
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int bad;
    n_cmp = 0; n_bad = 0;
    hi_m = '0; lo_m = '0;
    rst = 1'b1;
    bus.start = 1'b1; bus.op = 3'd6; bus.a = '0; bus.b = '0; bus.read_req = 1'b1;
    tick();
    tick();
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0; bus.start = 1'b0; bus.read_req = 1'b0;
    tick();

    // MTHI with idle unit, then an ignored op 6
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h12345678;
    tick();
    bus.start = 1'b0;
    hi_m = 32'h12345678;
    chk("mthi_hi", 64'(bus.hi), 64'(hi_m));
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_done", 64'(bus.done), 64'd0);
    tick();
    chk("mthi_done_after", 64'(bus.done), 64'd0);
    bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'hDEADBEEF;
    tick();
    bus.start = 1'b0;
    chk("op6_hi", 64'(bus.hi), 64'(hi_m));
    chk("op6_lo", 64'(bus.lo), 64'(lo_m));
    chk("op6_busy", 64'(bus.busy), 64'd0);

    run_md("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_md("mult_neg",  3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("mult_min",  3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_md("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("divu_by0",  3'd3, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
    run_md("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // DIV -7/2 with a read and an MTLO colliding with the busy unit
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'hFFFFFFF9; bus.b = 32'd2;
    tick();
    bus.start = 1'b0;
    bad = 0;
    for (int c = 1; c <= 33; c++) begin
      if (c == 5) begin
        bus.read_req = 1'b1; #1;
        chk("stall_read_busy", 64'(bus.stall), 64'd1);
      end
      if (c == 10) begin
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h0000AAAA; #1;
        chk("stall_start_busy", 64'(bus.stall), 64'd1);
      end
      if (c == 11) chk("mtlo_ignored_lo", 64'(bus.lo), 64'(lo_m));
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      tick();
      bus.read_req = 1'b0; bus.start = 1'b0;
    end
    chk("div_stall_window", 64'(bad), 64'd0);
    bus.read_req = 1'b1; bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h00005555; #1;
    chk("stall_done_cycle", 64'(bus.stall), 64'd0);
    chk("div_neg_done", 64'(bus.done), 64'd1);
    chk("div_neg_hi", 64'(bus.hi), 64'hFFFFFFFF);
    chk("div_neg_lo", 64'(bus.lo), 64'hFFFFFFFD);
    hi_m = 32'hFFFFFFFF;
    tick();
    bus.start = 1'b0; bus.read_req = 1'b0;
    lo_m = 32'h00005555;
    chk("mtlo_replay_lo", 64'(bus.lo), 64'(lo_m));
    chk("mtlo_replay_done", 64'(bus.done), 64'd0);
    chk("mtlo_replay_busy", 64'(bus.busy), 64'd0);

    // Reset in the middle of a divide, then a fresh MULTU
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd1000; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 12; c++) tick();
    chk("abort_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    run_md("multu_after_rst", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
